// File: rtl/csel_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
package csel_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_BLOCK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Legal when the word splits evenly into non-empty groups.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned block);
    return (block >= 1) && (width >= 2) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select group: both conditional sums and carries for a BLOCK-bit slice.
module csel_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic             c0,
  output logic [BLOCK-1:0] sum1,
  output logic             c1
);

  localparam int unsigned BW = BLOCK + 1;

  logic [BLOCK:0] r0;
  logic [BLOCK:0] r1;

  assign r0 = BW'(a) + BW'(b);
  assign r1 = BW'(a) + BW'(b) + BW'(1);

  assign sum0 = r0[BLOCK-1:0];
  assign c0   = r0[BLOCK];
  assign sum1 = r1[BLOCK-1:0];
  assign c1   = r1[BLOCK];

endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 ripples each group twice; stage 2 resolves the group carries by muxing.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  if (!cfg_legal(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("csel_adder_pipe: WIDTH must be >= 2 and a multiple of BLOCK");
  end

  // Operand conditioning
  logic             sub_mode;
  logic [WIDTH-1:0] yb_c;
  logic             cin_c;

  assign sub_mode = (mode_e'(sub) == MODE_SUB);
  assign yb_c     = sub_mode ? ~y : y;
  assign cin_c    = sub_mode ? 1'b1 : carry;

  // Flow control
  logic ld1;
  logic ld2;
  logic v1;
  logic acc;

  assign ld2      = !out_valid || out_ready;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;
  assign acc      = in_valid && ld1;

  // Conditional group results
  logic [WIDTH-1:0] sum0_c, sum1_c;
  logic [NBLK-1:0]  c0_c, c1_c;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    csel_block #(.BLOCK(BLOCK)) u_blk (
      .a    (x[k*BLOCK +: BLOCK]),
      .b    (yb_c[k*BLOCK +: BLOCK]),
      .sum0 (sum0_c[k*BLOCK +: BLOCK]),
      .c0   (c0_c[k]),
      .sum1 (sum1_c[k*BLOCK +: BLOCK]),
      .c1   (c1_c[k])
    );
  end

  // Stage 1 registers
  logic [WIDTH-1:0] sum0_q, sum1_q;
  logic [NBLK-1:0]  c0_q, c1_q;
  logic             cin_q, xmsb_q, ybmsb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      sum0_q  <= '0;
      sum1_q  <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      cin_q   <= 1'b0;
      xmsb_q  <= 1'b0;
      ybmsb_q <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (acc) begin
        sum0_q  <= sum0_c;
        sum1_q  <= sum1_c;
        c0_q    <= c0_c;
        c1_q    <= c1_c;
        cin_q   <= cin_c;
        xmsb_q  <= x[WIDTH-1];
        ybmsb_q <= yb_c[WIDTH-1];
      end
    end
  end

  // Carry selection chain across groups
  logic [NBLK:0]    chain;
  logic [WIDTH-1:0] sel_s;
  logic             ovf_c;

  assign chain[0] = cin_q;

  for (genvar k = 0; k < NBLK; k++) begin : g_sel
    assign sel_s[k*BLOCK +: BLOCK] = chain[k] ? sum1_q[k*BLOCK +: BLOCK]
                                              : sum0_q[k*BLOCK +: BLOCK];
    assign chain[k+1] = chain[k] ? c1_q[k] : c0_q[k];
  end

  assign ovf_c = (xmsb_q == ybmsb_q) && (sel_s[WIDTH-1] != xmsb_q);

  // Stage 2 registers drive the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (ld2) begin
      out_valid <= v1;
      if (v1) begin
        s    <= sel_s;
        cout <= chain[NBLK];
        ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed self-checking bench for csel_adder_pipe (WIDTH=16, BLOCK=4).
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic        carry, sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout, ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .carry     (carry),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; carry = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL reset_s got=%h exp=0000", s); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  // Single beats: {x, y, carry, sub, exp_s, exp_cout, exp_ovf}
  task automatic run_single(input logic [15:0] vx, input logic [15:0] vy, input logic vc,
                            input logic vs, input logic [15:0] es, input logic ec,
                            input logic eo, input string nm);
    x = vx; y = vy; carry = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; x = '0; y = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got=%b exp=0", nm, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b exp=1", nm, out_valid); end
    checks++; if (s !== es) begin errors++; $display("FAIL %s_s got=%h exp=%h", nm, s, es); end
    checks++; if (cout !== ec) begin errors++; $display("FAIL %s_cout got=%b exp=%b", nm, cout, ec); end
    checks++; if (ovf !== eo) begin errors++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf, eo); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got=%b exp=0", nm, out_valid); end
  endtask

  task automatic test_add();
    run_single(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_carry_ripple");
    run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    run_single(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, "add_cin_ovf");
  endtask

  task automatic test_sub();
    run_single(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ex [4] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    int sent = 0;
    int rcv  = 0;
    for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      x = 16'(16'h1000 * (sent + 1));
      y = 16'(sent + 1);
      carry = 1'b0; sub = 1'b0;
      #1;
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_drop got=%b exp=0", in_ready); end
      end
      if (cyc == 1 || cyc == 2) begin
        checks++; if (out_valid !== (cyc == 2)) begin errors++; $display("FAIL b2b_fill_valid cyc=%0d got=%b", cyc, out_valid); end
      end
      if (out_valid && rcv < 4) begin
        checks++;
        if (s !== ex[rcv]) begin errors++; $display("FAIL b2b_s idx=%0d stall=%b got=%h exp=%h", rcv, !out_ready, s, ex[rcv]); end
        if (out_ready) rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (rcv !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", rcv); end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    int rcv = 0;
    logic [15:0] ex;
    out_ready = 1'b1; carry = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      in_valid = (cyc < 20);
      x = 16'(cyc * 37);
      y = 16'(1000 - cyc);
      #1;
      if (cyc < 20) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
      end
      checks++;
      if (out_valid !== (cyc >= 2 && cyc < 22)) begin
        errors++; $display("FAIL stream_valid cyc=%0d got=%b", cyc, out_valid);
      end
      if (out_valid) begin
        ex = 16'(rcv * 37 + 1000 - rcv);
        checks++; if (s !== ex) begin errors++; $display("FAIL stream_s idx=%0d got=%h exp=%h", rcv, s, ex); end
        rcv++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (rcv !== 20) begin errors++; $display("FAIL stream_count got=%0d exp=20", rcv); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; carry = 1'b0; sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = 16'h0100 + 16'(i); y = 16'h0001; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill_valid got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL mid_async_s got=%h exp=0000", s); end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", i, out_valid); end
    end
    x = 16'h0011; y = 16'h0022; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_early got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got=%b exp=1", out_valid); end
    checks++; if (s !== 16'h0033) begin errors++; $display("FAIL mid_s got=%h exp=0033", s); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stream();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
